// File: rtl/fir_mc_pkg.sv
// Shared types, overflow-mode codes and width helpers for the multi-channel FIR.
package fir_mc_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_MAC,
    ST_SCALE,
    ST_OUT
  } state_t;

  localparam logic [1:0] OVF_SAT  = 2'b00;
  localparam logic [1:0] OVF_WRAP = 2'b01;
  localparam logic [1:0] OVF_FLAG = 2'b10;

  function automatic int tap_width(input int taps);
    return $clog2(taps);
  endfunction

  // A single channel still needs a one-bit channel field.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mc_filter_if.sv
// Sample stream with valid/ready handshake; used for both the input and output side.
interface fir_mc_filter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_W       = 2
);
  logic [DATA_WIDTH-1:0] data;
  logic [CH_W-1:0]       chan;
  logic                  valid;
  logic                  ready;

  modport master (output data, output chan, output valid, input ready);
  modport slave  (input data, input chan, input valid, output ready);
endinterface

// File: rtl/fir_mc_scale.sv
// Combinational round, arithmetic shift and saturate/wrap of the accumulator.
module fir_mc_scale
  import fir_mc_pkg::*;
#(
  parameter int ACC_WIDTH  = 35,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_SHIFT  = 15
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic [1:0]                  mode,
  output logic [DATA_WIDTH-1:0]       result,
  output logic                        ovf
);
  localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] RND =
    (OUT_SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RND_POS) : '0;
  localparam logic signed [ACC_WIDTH:0] MAXV =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

  // One guard bit so the rounding add itself cannot wrap.
  logic signed [ACC_WIDTH:0] sum;
  logic signed [ACC_WIDTH:0] r;
  logic                      ovf_hi;
  logic                      ovf_lo;
  logic [DATA_WIDTH-1:0]     sat_val;

  assign sum    = (ACC_WIDTH+1)'(acc) + RND;
  assign r      = sum >>> OUT_SHIFT;
  assign ovf_hi = r > MAXV;
  assign ovf_lo = r < MINV;
  assign ovf    = ovf_hi | ovf_lo;

  always_comb begin
    sat_val = r[DATA_WIDTH-1:0];
    if (ovf_hi)
      sat_val = MAXV[DATA_WIDTH-1:0];
    else if (ovf_lo)
      sat_val = MINV[DATA_WIDTH-1:0];
  end

  always_comb begin
    case (mode)
      OVF_WRAP, OVF_FLAG: result = r[DATA_WIDTH-1:0];
      OVF_SAT:            result = sat_val;
      default:            result = sat_val;
    endcase
  end

endmodule

// File: rtl/fir_mc_filter.sv
// Time-multiplexed multi-channel FIR: one MAC shared by CHANNELS sample histories,
// with shadow/active coefficient banks swapped at a sample boundary.
//   state    | meaning
//   ST_CLEAR | sweep addresses, zero all histories and both coefficient banks
//   ST_IDLE  | accept a sample; apply a pending coefficient commit first
//   ST_MAC   | TAPS products plus one cycle of read latency
//   ST_SCALE | round/shift/saturate accumulator into the output register
//   ST_OUT   | hold result until the sink accepts
module fir_mc_filter
  import fir_mc_pkg::*;
#(
  parameter int TAPS        = 128,
  parameter int CHANNELS    = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int OUT_SHIFT   = 15,
  localparam int TAP_W      = tap_width(TAPS),
  localparam int CH_W       = ch_width(CHANNELS),
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COEFF_WIDTH, TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  fir_mc_filter_if.slave         src,
  fir_mc_filter_if.master        snk,
  input  logic                   coeff_wr_en,
  input  logic [TAP_W-1:0]       coeff_addr,
  input  logic [COEFF_WIDTH-1:0] coeff_data,
  input  logic                   coeff_commit,
  output logic                   coeff_pending,
  input  logic [1:0]             overflow_mode,
  input  logic                   overflow_clr,
  output logic                   overflow_flag,
  output logic                   busy
);
  localparam logic [TAP_W:0] CNT_CLR_LAST = (TAP_W+1)'(TAPS - 1);
  localparam logic [TAP_W:0] CNT_MAC_LAST = (TAP_W+1)'(TAPS);

  state_t state, state_nx;
  logic [TAP_W:0]        cnt;
  logic [CH_W-1:0]       ch_q;
  logic [TAP_W-1:0]      wr_ptr [CHANNELS];
  logic [DATA_WIDTH-1:0] x_mem [CHANNELS][TAPS];
  logic [COEFF_WIDTH-1:0] coef [2][TAPS];
  logic [COEFF_WIDTH-1:0] shadow_nx [TAPS];
  logic                  bank_sel;
  logic                  sh_sel;
  logic signed [DATA_WIDTH-1:0]             x_q;
  logic signed [COEFF_WIDTH-1:0]            h_q;
  logic signed [DATA_WIDTH+COEFF_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]              acc;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CH_W-1:0]       out_chan_q;
  logic [DATA_WIDTH-1:0] scaled;
  logic                  scale_ovf;
  logic                  chan_ok, accept, accept_ok, swap, mac_last;
  logic [TAP_W-1:0]      tap_idx, rd_addr;

  if (CHANNELS == (1 << CH_W)) begin : g_chan_full
    assign chan_ok = 1'b1;
  end else begin : g_chan_part
    assign chan_ok = int'(src.chan) < CHANNELS;
  end

  assign accept    = (state == ST_IDLE) && src.valid;
  assign accept_ok = accept && chan_ok;
  assign swap      = (state == ST_IDLE) && coeff_pending;
  assign mac_last  = (state == ST_MAC) && (cnt == CNT_MAC_LAST);
  assign tap_idx   = cnt[TAP_W-1:0];
  assign rd_addr   = wr_ptr[ch_q] - tap_idx;
  assign sh_sel    = ~bank_sel;
  assign prod      = x_q * h_q;

  assign src.ready = (state == ST_IDLE);
  assign snk.valid = (state == ST_OUT);
  assign snk.data  = out_data_q;
  assign snk.chan  = out_chan_q;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (cnt == CNT_CLR_LAST) state_nx = ST_IDLE;
      ST_IDLE:  if (accept_ok) state_nx = ST_MAC;
      ST_MAC:   if (mac_last) state_nx = ST_SCALE;
      ST_SCALE: state_nx = ST_OUT;
      ST_OUT:   if (snk.ready) state_nx = ST_IDLE;
      default:  state_nx = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: cnt <= (cnt == CNT_CLR_LAST) ? '0 : cnt + (TAP_W+1)'(1);
        ST_MAC:   cnt <= mac_last ? '0 : cnt + (TAP_W+1)'(1);
        default:  cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q          <= '0;
      x_q           <= '0;
      h_q           <= '0;
      acc           <= '0;
      out_data_q    <= '0;
      out_chan_q    <= '0;
      overflow_flag <= 1'b0;
      coeff_pending <= 1'b0;
      bank_sel      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) wr_ptr[c] <= '0;
    end else begin
      if (accept_ok) begin
        ch_q <= src.chan;
        acc  <= '0;
      end
      if (state == ST_MAC) begin
        if (!mac_last) begin
          x_q <= x_mem[ch_q][rd_addr];
          h_q <= coef[bank_sel][tap_idx];
        end
        if (cnt != '0) acc <= acc + ACC_WIDTH'(prod);
        if (mac_last) wr_ptr[ch_q] <= wr_ptr[ch_q] + TAP_W'(1);
      end
      if (state == ST_SCALE) begin
        out_data_q <= scaled;
        out_chan_q <= ch_q;
      end
      if ((state == ST_SCALE) && scale_ovf) overflow_flag <= 1'b1;
      else if (overflow_clr)                 overflow_flag <= 1'b0;
      if (swap)              coeff_pending <= 1'b0;
      else if (coeff_commit) coeff_pending <= 1'b1;
      if (swap) bank_sel <= ~bank_sel;
    end
  end

  // On a swap both banks take the shadow image, so later partial writes build on it.
  always_comb begin
    for (int k = 0; k < TAPS; k++)
      shadow_nx[k] = (coeff_wr_en && (coeff_addr == TAP_W'(k))) ? coeff_data : coef[sh_sel][k];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (swap) begin
        for (int k = 0; k < TAPS; k++) begin
          coef[0][k] <= shadow_nx[k];
          coef[1][k] <= shadow_nx[k];
        end
      end else if (coeff_wr_en) begin
        coef[sh_sel][coeff_addr] <= coeff_data;
      end
      if (accept_ok) x_mem[src.chan][wr_ptr[src.chan]] <= src.data;
      if (state == ST_CLEAR) begin
        for (int c = 0; c < CHANNELS; c++) x_mem[c][tap_idx] <= '0;
        coef[0][tap_idx] <= '0;
        coef[1][tap_idx] <= '0;
      end
    end
  end

  fir_mc_scale #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_scale (
    .acc   (acc),
    .mode  (overflow_mode),
    .result(scaled),
    .ovf   (scale_ovf)
  );

endmodule

// File: tb/tb_fir_mc_filter.sv
// Directed bench for fir_mc_filter with TAPS=8, CHANNELS=2, OUT_SHIFT=0.
module tb_fir_mc_filter;
  localparam int TAPS = 8;
  localparam int CHANNELS = 2;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int CH_W = 1;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          coeff_wr_en = 1'b0;
  logic [TW-1:0] coeff_addr = '0;
  logic [CW-1:0] coeff_data = '0;
  logic          coeff_commit = 1'b0;
  logic          coeff_pending;
  logic [1:0]    overflow_mode = 2'b00;
  logic          overflow_clr = 1'b0;
  logic          overflow_flag;
  logic          busy;

  int n_checks = 0;
  int n_fail = 0;
  int guard;
  logic [CW-1:0] mac_coef [TAPS];

  fir_mc_filter_if #(.DATA_WIDTH(DW), .CH_W(CH_W)) src_if ();
  fir_mc_filter_if #(.DATA_WIDTH(DW), .CH_W(CH_W)) snk_if ();

  fir_mc_filter #(
    .TAPS(TAPS), .CHANNELS(CHANNELS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .OUT_SHIFT(0)
  ) dut (
    .clk(clk), .rst(rst), .src(src_if), .snk(snk_if),
    .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .coeff_commit(coeff_commit), .coeff_pending(coeff_pending),
    .overflow_mode(overflow_mode), .overflow_clr(overflow_clr),
    .overflow_flag(overflow_flag), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_coefs();
    for (int k = 0; k < TAPS; k++) begin
      coeff_wr_en = 1'b1;
      coeff_addr  = TW'(k);
      coeff_data  = mac_coef[k];
      tick();
    end
    coeff_wr_en  = 1'b0;
    coeff_commit = 1'b1;
    tick();
    coeff_commit = 1'b0;
    check("load_pending_set", 32'(coeff_pending), 32'd1);
    tick();
    check("load_pending_clr", 32'(coeff_pending), 32'd0);
  endtask

  // One sample through the filter; optional coefficient rewrite during MAC,
  // overflow_clr in the SCALE cycle, and output backpressure.
  task automatic send(input string tag, input logic ch, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp, input bit wr_mac, input bit clr_scale,
                      input int hold);
    int lat;
    int g;
    src_if.chan  = ch;
    src_if.data  = d;
    src_if.valid = 1'b1;
    snk_if.ready = (hold == 0);
    g = 0;
    while (!src_if.ready && g < 40) begin
      tick();
      g++;
    end
    check({tag, "_accept"}, 32'(src_if.ready), 32'd1);
    @(posedge clk);
    #1;
    src_if.valid = 1'b0;
    lat = 1;
    while (!snk_if.valid && lat < 40) begin
      coeff_wr_en  = wr_mac && (lat >= 1) && (lat <= TAPS);
      coeff_addr   = TW'(lat - 1);
      coeff_data   = mac_coef[(lat - 1) % TAPS];
      coeff_commit = wr_mac && (lat == TAPS + 1);
      overflow_clr = clr_scale && (lat == TAPS + 2);
      tick();
      lat++;
    end
    coeff_wr_en  = 1'b0;
    coeff_commit = 1'b0;
    overflow_clr = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(TAPS + 3));
    check({tag, "_data"}, 32'(snk_if.data), 32'(exp));
    check({tag, "_chan"}, 32'(snk_if.chan), 32'(ch));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_data"}, 32'(snk_if.data), 32'(exp));
      check({tag, "_hold_inrdy"}, 32'(src_if.ready), 32'd0);
    end
    snk_if.ready = 1'b1;
    tick();
    check({tag, "_next_inrdy"}, 32'(src_if.ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    src_if.valid = 1'b0;
    src_if.data  = '0;
    src_if.chan  = '0;
    snk_if.ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 32'(src_if.ready), 32'd0);
    check("rst_out_valid", 32'(snk_if.valid), 32'd0);
    check("rst_out_data", 32'(snk_if.data), 32'd0);
    check("rst_out_chan", 32'(snk_if.chan), 32'd0);
    check("rst_flag", 32'(overflow_flag), 32'd0);
    check("rst_pending", 32'(coeff_pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    guard = 0;
    while (!src_if.ready && guard < 20) begin
      tick();
      guard++;
    end
    check("clear_len", 32'(guard), 32'(TAPS));
    check("clear_busy", 32'(busy), 32'd0);

    // impulse response through h[k] = k+1
    for (int k = 0; k < TAPS; k++) mac_coef[k] = CW'(k + 1);
    load_coefs();
    for (int i = 0; i <= TAPS; i++)
      send("impulse", 1'b0, (i == 0) ? 16'd1 : 16'd0, (i < TAPS) ? DW'(i + 1) : 16'd0, 1'b0, 1'b0, 0);

    // channel isolation
    send("iso_c0a", 1'b0, 16'd1, 16'd1, 1'b0, 1'b0, 0);
    send("iso_c1a", 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 0);
    send("iso_c0b", 1'b0, 16'd0, 16'd2, 1'b0, 1'b0, 0);
    send("iso_c1b", 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 0);
    send("iso_c0c", 1'b0, 16'd0, 16'd3, 1'b0, 1'b0, 0);

    // commit during MAC: current output keeps old h[3]=4, next uses new g[4]
    for (int k = 0; k < TAPS; k++) mac_coef[k] = 16'h0100 + CW'(k);
    send("cmt_old", 1'b0, 16'd0, 16'd4, 1'b1, 1'b0, 0);
    check("cmt_pending_idle", 32'(coeff_pending), 32'd1);
    send("cmt_new", 1'b0, 16'd0, 16'h0104, 1'b0, 1'b0, 0);
    check("cmt_pending_done", 32'(coeff_pending), 32'd0);

    // backpressure
    send("bp", 1'b0, 16'd0, 16'h0105, 1'b0, 1'b0, 5);

    // overflow on ch1 with full-scale coefficients and samples
    for (int k = 0; k < TAPS; k++) mac_coef[k] = 16'h7FFF;
    load_coefs();
    overflow_mode = 2'b00;
    for (int i = 0; i < TAPS; i++)
      send("ovf_sat", 1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 0);
    check("ovf_flag_set", 32'(overflow_flag), 32'd1);
    overflow_mode = 2'b01;
    send("ovf_wrap", 1'b1, 16'h7FFF, 16'h0008, 1'b0, 1'b0, 0);
    overflow_mode = 2'b10;
    send("ovf_wrapflag", 1'b1, 16'h7FFF, 16'h0008, 1'b0, 1'b0, 0);
    overflow_mode = 2'b11;
    send("ovf_mode3", 1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_flag_clr", 32'(overflow_flag), 32'd0);
    overflow_mode = 2'b00;
    send("ovf_set_wins", 1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 0);
    check("ovf_flag_set_wins", 32'(overflow_flag), 32'd1);

    // reset mid-MAC with a pending commit
    src_if.chan  = 1'b0;
    src_if.data  = 16'd0;
    src_if.valid = 1'b1;
    @(posedge clk);
    #1;
    src_if.valid = 1'b0;
    tick();
    tick();
    coeff_commit = 1'b1;
    tick();
    coeff_commit = 1'b0;
    check("mid_pending", 32'(coeff_pending), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rst2_out_valid", 32'(snk_if.valid), 32'd0);
    check("rst2_in_ready", 32'(src_if.ready), 32'd0);
    check("rst2_pending", 32'(coeff_pending), 32'd0);
    check("rst2_flag", 32'(overflow_flag), 32'd0);
    check("rst2_out_data", 32'(snk_if.data), 32'd0);
    rst = 1'b0;
    guard = 0;
    while (!src_if.ready && guard < 20) begin
      tick();
      guard++;
    end
    check("clear2_len", 32'(guard), 32'(TAPS));
    for (int k = 0; k < TAPS; k++) mac_coef[k] = CW'(k + 1);
    load_coefs();
    send("post_rst_a", 1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 0);
    send("post_rst_b", 1'b1, 16'd0, 16'd2, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mc_filter.md
# fir_mc_filter

Time-multiplexed, multi-channel successor to the 128-tap FIR top. One MAC serves `CHANNELS` independent sample histories of `TAPS` depth. The block uses valid/ready handshakes on both sides and double-buffered (shadow/active) coefficients with a sample-boundary commit. It sits between the sample source and the output formatter, and keeps the existing saturate/wrap/flag overflow behaviour.

## Interface
- `TAPS`, 128: taps per channel, power of two, ≥4.
- `CHANNELS`, 4: independent channels, power of two, ≥1.
- `DATA_WIDTH`, 16: signed input/output sample width.
- `COEFF_WIDTH`, 16: signed coefficient width.
- `OUT_SHIFT`, 15: arithmetic right shift applied to the accumulator (Q1.15 coefficients).
- Derived: `ACC_WIDTH = DATA_WIDTH+COEFF_WIDTH+clog2(TAPS)`, `TAP_W = clog2(TAPS)`, `CH_W = max(1,clog2(CHANNELS))`.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_data`  in  DATA_WIDTH: input sample.
- `in_chan`  in  CH_W: channel of `in_data`.
- `in_valid`  in  1: input offered.
- `in_ready`  out  1: block can accept.
- `out_data`  out  DATA_WIDTH: filtered sample.
- `out_chan`  out  CH_W: channel of `out_data`.
- `out_valid`  out  1: output offered.
- `out_ready`  in  1: sink accepts.
- `coeff_wr_en`  in  1: write shadow coefficient bank.
- `coeff_addr`  in  TAP_W: tap index.
- `coeff_data`  in  COEFF_WIDTH: coefficient value.
- `coeff_commit`  in  1: request shadow→active copy.
- `coeff_pending`  out  1: commit requested, not yet applied.
- `overflow_mode`  in  2: 00 saturate, 01 wrap, 10 wrap+flag, 11 treated as 00.
- `overflow_clr`  in  1: clear sticky flag.
- `overflow_flag`  out  1: sticky overflow.
- `busy`  out  1: FSM not in IDLE.

## Operation
- FSM states: CLEAR → IDLE → MAC → SCALE → OUT → IDLE.
- CLEAR: entered on reset. Sweeps addresses 0..TAPS-1 and zeroes all channel histories and both coefficient banks. Takes TAPS cycles, then goes to IDLE.
- IDLE: `in_ready`=1. If `coeff_pending`, the shadow bank is copied to active (bank-select toggle) on the first IDLE cycle, before any accept in that cycle. `coeff_pending` clears.
- Accept (`in_valid & in_ready`): the sample is written at `wr_ptr[in_chan]` and the channel is latched. Accumulator clears. Go to MAC.
- `in_chan ≥ CHANNELS`: the handshake completes, the sample is discarded, and the FSM stays in IDLE. No output is produced.
- MAC: for k=0..TAPS-1, `acc += x[n-k]*h_active[k]`, where x is read at `(wr_ptr-k) mod TAPS`. Memory reads take one registered cycle, so MAC lasts TAPS+1 cycles. `wr_ptr[ch]` increments (wraps) at MAC end.
- SCALE: compute `r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT` (no rounding term if OUT_SHIFT=0). Overflow means r is outside the DATA_WIDTH signed range.
  - Mode 00/11: clamp to max/min.
  - Mode 01/10: keep the low DATA_WIDTH bits.
  - Any mode: overflow sets `overflow_flag`.
- OUT: hold `out_data`/`out_chan`, `out_valid`=1 until `out_ready`, then go to IDLE.
- Coefficient writes always target the shadow bank, in any state. The active bank never changes during MAC.
- `coeff_commit` while already pending: no effect. Writes after a commit and before the swap are included in the swap.
- `overflow_flag`: if set and `overflow_clr` occur in the same cycle, set wins.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `out_chan`=0.
  - `overflow_flag`=0, `coeff_pending`=0, `busy`=1.
  - All `wr_ptr`=0, bank select=0.
- `in_ready` first rises TAPS cycles after `rst` deasserts.
- Latency: `out_valid` rises TAPS+3 cycles after the accept edge, assuming `out_ready` is held high.
- Throughput: one sample per TAPS+4 cycles. `in_ready` is high in the cycle after the output handshake.
- `out_data`/`out_chan` are stable while `out_valid & !out_ready`.
- `rst` during any state aborts the operation. The next cycle is CLEAR with the reset values, and the pending commit is dropped.

## Structure
- Package `fir_mc_pkg`:
  - FSM state enum.
  - Overflow-mode constants (`OVF_SAT`, `OVF_WRAP`, `OVF_FLAG`).
  - `clog2`-derived width helpers.
- Sub-module `fir_mc_scale`: combinational round/shift/saturate/wrap plus overflow detect. It is registered by the top in SCALE.
- Top holds the FSM, per-channel pointers, sample RAM (CHANNELS×TAPS), two coefficient banks and the MAC.

## Test plan
Bench config: TAPS=8, CHANNELS=2, OUT_SHIFT=0.
- Reset release: `in_ready` low for 8 cycles, then high; all outputs at reset values; `busy` falls with `in_ready`.
- Impulse: coeffs h[k]=k+1 committed; ch0 inputs 1,0,0,0,0,0,0,0,0 → outputs 1,2,…,8,0, each with `out_chan`=0 and each 11 cycles after its accept.
- Channel isolation: interleave ch0 impulse with ch1 all-zero samples → ch1 outputs all 0; ch0 sequence unchanged. A sample with `in_chan`=2 (when CH_W allows) produces no output.
- Overflow: all coeffs 0x7FFF, input 0x7FFF repeated 8 times.
  - Mode 00 → 8th output 0x7FFF, flag=1.
  - Mode 01 → low 16 bits of 8·0x3FFF0001.
  - `overflow_clr` together with a new overflow → flag stays 1.
- Commit: write new coeffs during MAC and pulse `coeff_commit` → current output uses old coeffs; `coeff_pending`=1 until next IDLE; next output uses new coeffs.
- Backpressure/reset: hold `out_ready`=0 for 5 cycles → `out_data` stable, `in_ready`=0. Assert `rst` mid-MAC → `out_valid`=0 next cycle; after CLEAR, impulse gives h[0] only (history zeroed).
